// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - per-frame sequencer for game-logic update tasks
//
// On an accepted frame_end the enabled tasks are started one at a time in
// ascending index order under a start/done handshake with a per-task timeout.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   frame_end      end-of-frame pulse; accepted in IDLE while enable is high
//   enable         gates frame_end acceptance only
//   task_mask      tasks to run this frame, latched on the accepting frame_end
//   task_done      per-task completion, only the current task's bit is observed
//   clear_err      clears timeout_err / timeout_idx
//   task_start     one-hot, one-cycle start pulse
//   busy           high from first start pulse until last task retires
//   frame_done     one-cycle pulse when a frame's sequence completes
//   frame_overrun  one-cycle pulse when frame_end arrives while busy
//   timeout_err    sticky timeout flag
//   timeout_idx    index of the most recent timed-out task
//   frame_count    completed frames, wraps at 256
module frame_update_scheduler #(
    parameter int NUM_TASKS      = 5,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TMR_W          = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_end,
    input  logic                 enable,
    input  logic [NUM_TASKS-1:0] task_mask,
    input  logic [NUM_TASKS-1:0] task_done,
    input  logic                 clear_err,
    output logic [NUM_TASKS-1:0] task_start,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_overrun,
    output logic                 timeout_err,
    output logic [2:0]           timeout_idx,
    output logic [7:0]           frame_count
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state;
    logic [NUM_TASKS-1:0] mask_q;
    logic [2:0]           cur;
    logic [TMR_W-1:0]     timer;

    logic       first_found;
    logic [2:0] first_idx;
    logic       next_found;
    logic [2:0] next_idx;

    // Lowest set bit of the incoming mask, and lowest latched bit above cur.
    // Scanning downward lets the last hit be the lowest index.
    always_comb begin
        first_found = 1'b0;
        first_idx   = 3'd0;
        next_found  = 1'b0;
        next_idx    = 3'd0;
        for (int i = NUM_TASKS - 1; i >= 0; i--) begin
            if (task_mask[i]) begin
                first_found = 1'b1;
                first_idx   = 3'(i);
            end
            if (mask_q[i] && (3'(i) > cur)) begin
                next_found = 1'b1;
                next_idx   = 3'(i);
            end
        end
    end

    // The start-pulse cycle is excluded from done/timeout evaluation and the
    // timer holds at 0 through it, so done is first seen the cycle after start.
    logic in_start;
    logic cur_done;
    logic timer_hit;
    logic done_now;
    logic tmo_now;
    logic retire;

    assign in_start  = |task_start;
    assign cur_done  = task_done[cur];
    assign timer_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign done_now  = !in_start && cur_done;
    assign tmo_now   = !in_start && !cur_done && timer_hit;
    assign retire    = done_now || tmo_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mask_q        <= '0;
            cur           <= 3'd0;
            timer         <= '0;
            task_start    <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
            timeout_err   <= 1'b0;
            timeout_idx   <= 3'd0;
            frame_count   <= 8'd0;
        end else begin
            task_start    <= '0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;

            // A timeout in the same cycle overrides this clear below.
            if (clear_err) begin
                timeout_err <= 1'b0;
                timeout_idx <= 3'd0;
            end

            case (state)
                IDLE: begin
                    if (frame_end && enable) begin
                        mask_q <= task_mask;
                        if (first_found) begin
                            task_start <= NUM_TASKS'(1) << first_idx;
                            busy       <= 1'b1;
                            cur        <= first_idx;
                            timer      <= '0;
                            state      <= WAIT;
                        end else begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end
                    end
                end

                WAIT: begin
                    // Frames arriving while busy are dropped, not queued.
                    if (frame_end) begin
                        frame_overrun <= 1'b1;
                    end
                    if (tmo_now) begin
                        timeout_err <= 1'b1;
                        timeout_idx <= cur;
                    end
                    if (retire) begin
                        timer <= '0;
                        if (next_found) begin
                            task_start <= NUM_TASKS'(1) << next_idx;
                            cur        <= next_idx;
                        end else begin
                            frame_done  <= 1'b1;
                            busy        <= 1'b0;
                            frame_count <= frame_count + 8'd1;
                            state       <= IDLE;
                        end
                    end else if (!in_start) begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
